// File: rtl/pkt_gen_pkg.sv
// Shared types and helpers for the buffered packet generator.
//   flit_t    : packed flit at the default field widths {dest, ptype, payload, eop}
//   state_e   : wormhole framing state (SOP = expecting first flit, MID = inside packet)
//   pkt_width : packed flit width for a given set of field widths
//   pack_flit : packs a default-width flit_t MSB first
package pkt_gen_pkg;

    localparam int unsigned DEST_W_DEF = 2;
    localparam int unsigned TYPE_W_DEF = 2;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned PKT_W_DEF  = DEST_W_DEF + TYPE_W_DEF + DATA_W_DEF + 1;

    typedef struct packed {
        logic [DEST_W_DEF-1:0] dest;
        logic [TYPE_W_DEF-1:0] ptype;
        logic [DATA_W_DEF-1:0] payload;
        logic                  eop;
    } flit_t;

    typedef enum logic {
        SOP = 1'b0,
        MID = 1'b1
    } state_e;

    function automatic int unsigned pkt_width(input int unsigned dest_w,
                                              input int unsigned type_w,
                                              input int unsigned data_w);
        return dest_w + type_w + data_w + 1;
    endfunction

    function automatic logic [PKT_W_DEF-1:0] pack_flit(input flit_t f);
        return {f.dest, f.ptype, f.payload, f.eop};
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous first-word-fall-through FIFO with registered storage.
//   clk, rst    : clock, synchronous active-high reset
//   push, din   : write request and data (ignored when full)
//   pop         : read request (ignored when empty)
//   dout        : current head entry (valid while !empty)
//   full, empty : occupancy flags from registered level
//   level       : number of stored entries
module pkt_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy next-state; pointers wrap at DEPTH (power of two).
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted in level.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/packet_gen_buf.sv
// Buffered wormhole packet generator.
//   clk, rst                         : clock, synchronous active-high reset
//   router_destination, packet_type  : header fields, sampled on the first flit only
//   payload, end_of_packet, valid    : producer flit and handshake; ready back-pressures
//   src_valid, src_ready, packet     : router-side handshake, packet = {dest,type,payload,eop}
//   level                            : FIFO occupancy
//   trunc_err                        : one-cycle pulse after a packet is force-terminated
//   pkt_count                        : delivered packets (eop popped), wraps mod 2^16
module packet_gen_buf
    import pkt_gen_pkg::*;
#(
    parameter int unsigned DEST_W    = 2,
    parameter int unsigned TYPE_W    = 2,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_FLITS = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DEST_W-1:0]                router_destination,
    input  logic [TYPE_W-1:0]                packet_type,
    input  logic [DATA_W-1:0]                payload,
    input  logic                             end_of_packet,
    input  logic                             valid,
    output logic                             ready,
    output logic                             src_valid,
    input  logic                             src_ready,
    output logic [DEST_W+TYPE_W+DATA_W:0]    packet,
    output logic [$clog2(DEPTH):0]           level,
    output logic                             trunc_err,
    output logic [15:0]                      pkt_count
);

    localparam int unsigned PKT_W = pkt_width(DEST_W, TYPE_W, DATA_W);
    localparam int unsigned CNT_W = $clog2(MAX_FLITS + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nxt;
    logic [DEST_W-1:0]   dest_q, dest_d, flit_dest;
    logic [TYPE_W-1:0]   type_q, type_d, flit_type;
    logic                trunc_q, trunc_d;
    logic [15:0]         pkt_count_q, pkt_count_d;
    logic                acc, pop, force_eop, flit_eop;
    logic                fifo_full, fifo_empty;
    logic [PKT_W-1:0]    fifo_din, fifo_dout;

    assign ready     = ~fifo_full;
    assign src_valid = ~fifo_empty;
    assign acc       = valid & ready;
    assign pop       = src_valid & src_ready;
    assign fifo_din  = {flit_dest, flit_type, payload, flit_eop};
    assign packet    = fifo_empty ? '0 : fifo_dout;
    assign trunc_err = trunc_q;
    assign pkt_count = pkt_count_q;

    // Framing: header comes live on SOP, from the latch inside a packet;
    // the MAX_FLITS-th flit without eop gets eop forced and flags truncation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dest_d      = dest_q;
        type_d      = type_q;
        flit_dest   = dest_q;
        flit_type   = type_q;
        cnt_nxt     = cnt_q + CNT_W'(1);
        if (state_q == SOP) begin
            flit_dest = router_destination;
            flit_type = packet_type;
            cnt_nxt   = CNT_W'(1);
        end
        force_eop   = ~end_of_packet & (cnt_nxt == CNT_W'(MAX_FLITS));
        flit_eop    = end_of_packet | force_eop;
        trunc_d     = acc & force_eop;
        if (acc) begin
            cnt_d = cnt_nxt;
            if (state_q == SOP) begin
                dest_d = router_destination;
                type_d = packet_type;
            end
            state_d = flit_eop ? SOP : MID;
        end
        pkt_count_d = pkt_count_q + ((pop && fifo_dout[0]) ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SOP;
            cnt_q       <= '0;
            dest_q      <= '0;
            type_q      <= '0;
            trunc_q     <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dest_q      <= dest_d;
            type_q      <= type_d;
            trunc_q     <= trunc_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (acc),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: tb/tb_packet_gen_buf.sv
// Directed bench for packet_gen_buf (DEPTH=4, MAX_FLITS=4).
module tb_packet_gen_buf;
    import pkt_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  router_destination;
    logic [1:0]  packet_type;
    logic [7:0]  payload;
    logic        end_of_packet;
    logic        valid;
    logic        ready;
    logic        src_valid;
    logic        src_ready;
    logic [12:0] packet;
    logic [2:0]  level;
    logic        trunc_err;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    packet_gen_buf #(
        .DEST_W(2), .TYPE_W(2), .DATA_W(8), .DEPTH(4), .MAX_FLITS(4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .router_destination (router_destination),
        .packet_type        (packet_type),
        .payload            (payload),
        .end_of_packet      (end_of_packet),
        .valid              (valid),
        .ready              (ready),
        .src_valid          (src_valid),
        .src_ready          (src_ready),
        .packet             (packet),
        .level              (level),
        .trunc_err          (trunc_err),
        .pkt_count          (pkt_count)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  dest;
        logic [1:0]  ptype;
        logic [7:0]  pl;
        logic        eop;
        logic        sr;
        logic        exp_rdy;
        logic        exp_sv;
        logic [12:0] exp_pkt;
        logic [2:0]  exp_lvl;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [12:0] pk(input logic [1:0] d, input logic [1:0] t,
                                       input logic [7:0] p, input logic e);
        flit_t f;
        f.dest    = d;
        f.ptype   = t;
        f.payload = p;
        f.eop     = e;
        return pack_flit(f);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [1:0] t,
                         input logic [7:0] p, input logic e, input logic sr);
        valid              = v;
        router_destination = d;
        packet_type        = t;
        payload            = p;
        end_of_packet      = e;
        src_ready          = sr;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_src_valid", 32'(src_valid), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_packet", 32'(packet), 32'd0);
        chk("rst_trunc", 32'(trunc_err), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);

        // Outputs observed before each vector's clock edge.
        // v0-v1: single flit packet; v2-v8: 3-flit packet, later flits drive dest=0,type=3.
        vecs[0] = '{1'b1, 2'd2, 2'd1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 13'h0, 3'd0, 16'd0};
        vecs[1] = '{1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 13'b10_01_10100101_1, 3'd1, 16'd0};
        vecs[2] = '{1'b1, 2'd2, 2'd1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0, 3'd0, 16'd1};
        vecs[3] = '{1'b1, 2'd0, 2'd3, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, pk(2'd2, 2'd1, 8'h11, 1'b0), 3'd1, 16'd1};
        vecs[4] = '{1'b1, 2'd0, 2'd3, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, pk(2'd2, 2'd1, 8'h11, 1'b0), 3'd2, 16'd1};
        vecs[5] = '{1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, pk(2'd2, 2'd1, 8'h11, 1'b0), 3'd3, 16'd1};
        vecs[6] = '{1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, pk(2'd2, 2'd1, 8'h22, 1'b0), 3'd2, 16'd1};
        vecs[7] = '{1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, pk(2'd2, 2'd1, 8'h33, 1'b1), 3'd1, 16'd1};
        vecs[8] = '{1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0, 3'd0, 16'd2};

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].valid, vecs[i].dest, vecs[i].ptype, vecs[i].pl, vecs[i].eop, vecs[i].sr);
            chk($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].exp_rdy));
            chk($sformatf("v%0d_src_valid", i), 32'(src_valid), 32'(vecs[i].exp_sv));
            chk($sformatf("v%0d_packet", i), 32'(packet), 32'(vecs[i].exp_pkt));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].exp_lvl));
            chk($sformatf("v%0d_pkt_count", i), 32'(pkt_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_trunc", i), 32'(trunc_err), 32'd0);
            step();
        end

        // Backpressure: four single-flit packets fill the FIFO, fifth is held.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd1, 2'd2, 8'(8'h40 + i), 1'b1, 1'b0);
            chk($sformatf("bp_ready_%0d", i), 32'(ready), 32'd1);
            step();
        end
        chk("bp_full_level", 32'(level), 32'd4);
        chk("bp_full_ready", 32'(ready), 32'd0);
        drive(1'b1, 2'd1, 2'd2, 8'h44, 1'b1, 1'b0);
        step();
        step();
        chk("bp_hold_level", 32'(level), 32'd4);
        chk("bp_hold_ready", 32'(ready), 32'd0);
        chk("bp_hold_head", 32'(packet), 32'(pk(2'd1, 2'd2, 8'h40, 1'b1)));
        src_ready = 1'b1;
        step();
        chk("bp_ready_back", 32'(ready), 32'd1);
        chk("bp_level_3", 32'(level), 32'd3);
        chk("bp_head_41", 32'(packet), 32'(pk(2'd1, 2'd2, 8'h41, 1'b1)));
        step();
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_drain_head_%0d", i), 32'(packet), 32'(pk(2'd1, 2'd2, 8'(8'h42 + i), 1'b1)));
            chk($sformatf("bp_drain_level_%0d", i), 32'(level), 32'(3 - i));
            step();
        end
        chk("bp_empty", 32'(src_valid), 32'd0);
        chk("bp_pkt_count", 32'(pkt_count), 32'd7);

        // Truncation: six flits, no eop; flit 4 forced eop, flit 5 is a fresh SOP.
        begin
            logic [1:0]  td [6];
            logic [1:0]  tt [6];
            logic [12:0] te [6];
            td = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
            tt = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0};
            te = '{pk(2'd3, 2'd0, 8'h60, 1'b0), pk(2'd3, 2'd0, 8'h61, 1'b0),
                   pk(2'd3, 2'd0, 8'h62, 1'b0), pk(2'd3, 2'd0, 8'h63, 1'b1),
                   pk(2'd2, 2'd3, 8'h64, 1'b0), pk(2'd2, 2'd3, 8'h65, 1'b0)};
            for (int i = 0; i < 6; i++) begin
                drive(1'b1, td[i], tt[i], 8'(8'h60 + i), 1'b0, 1'b1);
                step();
                chk($sformatf("tr_head_%0d", i), 32'(packet), 32'(te[i]));
                chk($sformatf("tr_level_%0d", i), 32'(level), 32'd1);
                chk($sformatf("tr_trunc_%0d", i), 32'(trunc_err), (i == 3) ? 32'd1 : 32'd0);
            end
            valid = 1'b0;
            step();
            chk("tr_empty", 32'(level), 32'd0);
            chk("tr_pkt_count", 32'(pkt_count), 32'd8);
        end

        // Simultaneous push/pop at level 2; first flit closes the open packet.
        drive(1'b1, 2'd0, 2'd0, 8'h70, 1'b1, 1'b0);
        step();
        drive(1'b1, 2'd1, 2'd1, 8'h71, 1'b1, 1'b0);
        step();
        chk("sim_level_2", 32'(level), 32'd2);
        chk("sim_head_70", 32'(packet), 32'(pk(2'd2, 2'd3, 8'h70, 1'b1)));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd1, 2'd1, 8'(8'h72 + i), 1'b1, 1'b1);
            step();
            chk($sformatf("sim_level_%0d", i), 32'(level), 32'd2);
            chk($sformatf("sim_head_%0d", i), 32'(packet), 32'(pk(2'd1, 2'd1, 8'(8'h71 + i), 1'b1)));
        end
        valid = 1'b0;
        step();
        chk("sim_tail_head", 32'(packet), 32'(pk(2'd1, 2'd1, 8'h75, 1'b1)));
        step();
        chk("sim_empty", 32'(level), 32'd0);
        chk("sim_pkt_count", 32'(pkt_count), 32'd14);

        // Reset mid-packet after two flits of a three-flit packet.
        drive(1'b1, 2'd2, 2'd1, 8'h80, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'd2, 2'd1, 8'h81, 1'b0, 1'b0);
        step();
        chk("mr_level_2", 32'(level), 32'd2);
        valid = 1'b0;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
        chk("mr_level", 32'(level), 32'd0);
        chk("mr_src_valid", 32'(src_valid), 32'd0);
        chk("mr_ready", 32'(ready), 32'd1);
        chk("mr_pkt_count", 32'(pkt_count), 32'd0);
        chk("mr_packet", 32'(packet), 32'd0);
        drive(1'b1, 2'd3, 2'd2, 8'h90, 1'b0, 1'b1);
        step();
        chk("mr_sop_head", 32'(packet), 32'(pk(2'd3, 2'd2, 8'h90, 1'b0)));
        drive(1'b1, 2'd0, 2'd0, 8'h91, 1'b1, 1'b1);
        step();
        chk("mr_mid_head", 32'(packet), 32'(pk(2'd3, 2'd2, 8'h91, 1'b1)));
        valid = 1'b0;
        step();
        chk("mr_final_count", 32'(pkt_count), 32'd1);
        chk("mr_final_level", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_gen_buf.md
Name: packet_gen_buf

Overview:
- Parametrised, buffered successor to the combinational packet generator.
- Accepts one flit per cycle from a producer via valid/ready and packs it as {router_destination, packet_type, payload, end_of_packet}.
- Enforces wormhole consistency: dest/type are locked for the whole packet, and packets are limited to a maximum length.
- Buffers flits in a FIFO and presents them to the router source port with a valid/ready handshake; also counts delivered packets.

Parameters:
- DEST_W, 2, router_destination width
- TYPE_W, 2, packet_type width
- DATA_W, 8, payload width
- DEPTH, 4, FIFO depth in flits; power of two, >= 2
- MAX_FLITS, 16, maximum flits per packet; >= 1
- Derived: PKT_W = DEST_W+TYPE_W+DATA_W+1 (13 at defaults); CNT_W = $clog2(MAX_FLITS+1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- router_destination  in  DEST_W  destination; sampled only on the first flit of a packet
- packet_type  in  TYPE_W  type; sampled only on the first flit of a packet
- payload  in  DATA_W  flit data
- end_of_packet  in  1  last flit of packet
- valid  in  1  producer flit valid
- ready  out  1  block can accept a flit
- src_valid  out  1  packet output valid
- src_ready  in  1  router accepts the output flit
- packet  out  PKT_W  {dest, type, payload, eop}, MSB first
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- trunc_err  out  1  one-cycle pulse when a packet is force-terminated
- pkt_count  out  16  packets delivered (eop popped); wraps at 0xFFFF -> 0

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FIFO flushed; level=0, src_valid=0, ready=1 on the following cycle.
  - FSM=SOP, flit counter=0, trunc_err=0, pkt_count=0.
  - packet output is don't-care while src_valid=0; drive 0.
  - Reset mid-packet discards all buffered and partial flits; no eop is synthesised.
- Handshakes:
  - Accept: acc = valid & ready. ready = (level != DEPTH), taken from registered state.
  - Pop: pop = src_valid & src_ready. src_valid = (level != 0).
  - packet shows the FIFO head (first-word fall-through from registered storage).
  - No input-to-output bypass: latency from accept to src_valid is 1 cycle.
  - Simultaneous acc and pop: level unchanged, both take effect. When full, ready=0, so no push occurs even if a pop happens that cycle.
  - src_valid and packet hold stable until popped.
- FSM (states SOP, MID):
  - SOP, acc:
    - Latch dest/type; the flit uses the live inputs.
    - cnt = 1.
    - If eop or MAX_FLITS==1, stay in SOP; otherwise go to MID.
  - MID, acc:
    - Flit dest/type = latched values; live inputs are ignored.
    - cnt += 1.
    - If eop, go to SOP.
    - Else if cnt+1 == MAX_FLITS, the stored eop is forced to 1, trunc_err pulses in the cycle after acc, and the FSM goes to SOP.
  - Forced truncation: the next accepted flit starts a new packet with freshly sampled dest/type.
  - No acc: state and counter hold.
- Counters:
  - pkt_count increments by 1 on each pop whose eop bit is 1.
  - pkt_count wraps modulo 2^16.
- FIFO:
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
  - level is maintained by a separate counter.

Decomposition:
- Package pkt_gen_pkg holds:
  - typedef of the flit struct (dest, type, payload, eop), parametrised via localparams at the default widths;
  - the state enum {SOP, MID};
  - the PKT_W packing function.
- Sub-module pkt_fifo (synchronous FWFT FIFO; parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, level).
- The FSM, latches and counters live in the top level.

Test Plan:
- Single 1-flit packet: dest=2, type=1, payload=0xA5, eop=1, src_ready=1 -> next cycle src_valid=1, packet=13'b10_01_10100101_1; pkt_count becomes 1 after the pop.
- 3-flit packet where flits 2-3 drive dest=0, type=3 -> all three output flits carry dest=2, type=1; eop appears only on the third.
- Backpressure: src_ready=0, push 5 flits at DEPTH=4 -> ready drops after the 4th accept and level=4; the 5th flit is held by the producer. Raise src_ready -> flits drain in order and ready returns the cycle after the first pop.
- Truncation with MAX_FLITS=4: stream 6 flits with no eop -> flit 4 output has eop=1 and trunc_err pulses once; flit 5 is the SOP of a new packet with freshly sampled dest.
- Simultaneous push/pop at level=2 with continuous valid and src_ready -> level stays 2, throughput is 1 flit per cycle, order is preserved.
- Reset mid-packet: assert rst after 2 flits of a 3-flit packet with level=2 -> next cycle level=0, src_valid=0, ready=1; the next flit is treated as SOP; pkt_count=0.
